// File: rtl/count_alarm_queue_if.sv
// Request and fire handshake channels of the alarm queue.
interface count_alarm_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ID_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_time;
  logic [ID_W-1:0]  in_id;
  logic             fire_valid;
  logic             fire_ready;
  logic [ID_W-1:0]  fire_id;
  logic [WIDTH-1:0] fire_time;
  logic             fire_late;

  modport master (
    output in_valid, in_time, in_id, fire_ready,
    input  in_ready, fire_valid, fire_id, fire_time, fire_late
  );

  modport slave (
    input  in_valid, in_time, in_id, fire_ready,
    output in_ready, fire_valid, fire_id, fire_time, fire_late
  );
endinterface

// File: rtl/count_alarm_queue.sv
// FIFO of alarm requests fired in order when the free-running count reaches each target.
// Optional macro ALARM_LATE_DROP_EN silently drops alarms that are already late on arrival.
module count_alarm_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [7:0]               late_drops,
  count_alarm_queue_if.slave       bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] One  = {{PtrW{1'b0}}, 1'b1};
  localparam logic [PtrW:0] Full = {1'b1, {PtrW{1'b0}}};
  localparam logic [WIDTH-1:0] Half = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StEmpty, StWait, StFire} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] time_q [DEPTH];
  logic [ID_W-1:0]  id_q   [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    pending_q, pending_d;
  logic [WIDTH-1:0] count_q, head_time, diff;
  logic             push, pop, due, fire_load, last_entry;
  logic             fire_valid_q, fire_late_q;
  logic [ID_W-1:0]  fire_id_q;
  logic [WIDTH-1:0] fire_time_q;

  assign bus.in_ready = (pending_q != Full) & ~flush;
  assign push         = bus.in_valid & bus.in_ready;
  assign head_time    = time_q[rd_ptr_q];
  // Wrap-aware: anything less than half the range behind count is due.
  assign diff         = count_q - head_time;
  assign due          = diff < Half;
  assign last_entry   = (pending_q == One) & ~push;

`ifdef ALARM_LATE_DROP_EN
  logic       fresh_q, fresh_d, drop;
  logic [7:0] late_q;
`endif

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    fire_load = 1'b0;
`ifdef ALARM_LATE_DROP_EN
    drop      = 1'b0;
`endif
    unique case (state_q)
      StEmpty: if (push) state_d = StWait;
      StWait: begin
        if (due) begin
`ifdef ALARM_LATE_DROP_EN
          if (fresh_q && (count_q != head_time)) begin
            drop    = 1'b1;
            pop     = 1'b1;
            state_d = last_entry ? StEmpty : StWait;
          end else begin
            fire_load = 1'b1;
            state_d   = StFire;
          end
`else
          fire_load = 1'b1;
          state_d   = StFire;
`endif
        end
      end
      StFire: begin
        if (bus.fire_ready) begin
          pop     = 1'b1;
          state_d = last_entry ? StEmpty : StWait;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d   = StEmpty;
      pop       = 1'b0;
      fire_load = 1'b0;
`ifdef ALARM_LATE_DROP_EN
      drop      = 1'b0;
`endif
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (flush) pending_d = '0;
    else if (push && !pop) pending_d = pending_q + One;
    else if (pop && !push) pending_d = pending_q - One;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      time_q[wr_ptr_q] <= bus.in_time;
      id_q[wr_ptr_q]   <= bus.in_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pending_q    <= '0;
      count_q      <= '0;
      fire_valid_q <= 1'b0;
      fire_id_q    <= '0;
      fire_time_q  <= '0;
      fire_late_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      count_q      <= count;
      fire_valid_q <= (state_d == StFire);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (fire_load) begin
        fire_id_q   <= id_q[rd_ptr_q];
        fire_time_q <= count_q;
        fire_late_q <= (count_q != head_time);
      end
    end
  end

`ifdef ALARM_LATE_DROP_EN
  // A head is judged late only on its first compare cycle.
  assign fresh_d = (state_d == StWait) && ((state_q != StWait) || drop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fresh_q <= 1'b0;
      late_q  <= '0;
    end else begin
      fresh_q <= fresh_d;
      if (drop && (late_q != 8'hFF)) late_q <= late_q + 8'd1;
    end
  end

  assign late_drops = late_q;
`else
  assign late_drops = '0;
`endif

  assign pending        = pending_q;
  assign bus.fire_valid = fire_valid_q;
  assign bus.fire_id    = fire_id_q;
  assign bus.fire_time  = fire_time_q;
  assign bus.fire_late  = fire_late_q;
endmodule

// File: tb/tb_count_alarm_queue.sv
// Directed bench for count_alarm_queue: fire latency, FIFO order, wrap, late, flush, reset.
module tb_count_alarm_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] count = '0;
  logic        flush = 1'b0;
  logic [2:0]  pending;
  logic [7:0]  late_drops;
  int          total = 0;
  int          bad   = 0;

  count_alarm_queue_if #(.WIDTH(32), .ID_W(4)) bus ();

  count_alarm_queue #(.WIDTH(32), .DEPTH(4), .ID_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .count      (count),
    .flush      (flush),
    .pending    (pending),
    .late_drops (late_drops),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] t, input logic [3:0] id);
    bus.in_valid = 1'b1;
    bus.in_time  = t;
    bus.in_id    = id;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_time = '0; bus.in_id = '0; bus.fire_ready = 1'b0;
    #12;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
    total++; if (bus.fire_valid !== 1'b0) begin bad++; $display("FAIL rst_fire_valid got=%0b exp=0", bus.fire_valid); end
    total++; if (bus.fire_id !== 4'd0) begin bad++; $display("FAIL rst_fire_id got=%0h exp=0", bus.fire_id); end
    total++; if (bus.fire_time !== 32'd0) begin bad++; $display("FAIL rst_fire_time got=%0h exp=0", bus.fire_time); end
    total++; if (bus.fire_late !== 1'b0) begin bad++; $display("FAIL rst_fire_late got=%0b exp=0", bus.fire_late); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", pending); end
    total++; if (late_drops !== 8'd0) begin bad++; $display("FAIL rst_late_drops got=%0d exp=0", late_drops); end
    #4 reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    count = 90;
    push(100, 3);
    total++; if (pending !== 3'd1) begin bad++; $display("FAIL basic_pending1 got=%0d exp=1", pending); end
    for (int c = 91; c <= 101; c++) begin
      count = c;
      step();
      total++;
      if (bus.fire_valid !== (c == 101)) begin
        bad++; $display("FAIL basic_valid count=%0d got=%0b exp=%0b", c, bus.fire_valid, c == 101);
      end
    end
    total++; if (bus.fire_id !== 4'd3) begin bad++; $display("FAIL basic_id got=%0h exp=3", bus.fire_id); end
    total++; if (bus.fire_time !== 32'd100) begin bad++; $display("FAIL basic_time got=%0d exp=100", bus.fire_time); end
    total++; if (bus.fire_late !== 1'b0) begin bad++; $display("FAIL basic_late got=%0b exp=0", bus.fire_late); end
    bus.fire_ready = 1'b1; count = 102;
    step();
    bus.fire_ready = 1'b0;
    total++; if (bus.fire_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_valid got=%0b exp=0", bus.fire_valid); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL basic_pending0 got=%0d exp=0", pending); end
  endtask

  task automatic test_full();
    int  nfire = 0;
    int  cyc = 0;
    bit  accepted;
    count = 0;
    for (int i = 0; i < 4; i++) push(32'(10 * (i + 1)), 4'(i));
    bus.in_valid = 1'b1; bus.in_time = 50; bus.in_id = 4;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_pending got=%0d exp=4", pending); end
    bus.fire_ready = 1'b1;
    while (nfire < 5 && cyc < 120) begin
      accepted = bus.in_valid && bus.in_ready;
      total++;
      if (accepted && nfire == 0) begin
        bad++; $display("FAIL full_early_push got=accepted exp=held");
      end
      count = count + 1;
      step();
      cyc++;
      if (accepted) bus.in_valid = 1'b0;
      if (bus.fire_valid) begin
        total++;
        if (bus.fire_id !== 4'(nfire) || bus.fire_time !== 32'(10 * (nfire + 1)) || bus.fire_late) begin
          bad++;
          $display("FAIL full_order got=id%0d/t%0d/l%0b exp=id%0d/t%0d/l0", bus.fire_id,
                   bus.fire_time, bus.fire_late, nfire, 10 * (nfire + 1));
        end
        nfire++;
      end
    end
    total++; if (nfire != 5) begin bad++; $display("FAIL full_fire_count got=%0d exp=5", nfire); end
    count = count + 1;
    step();
    bus.fire_ready = 1'b0; bus.in_valid = 1'b0;
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", pending); end
  endtask

  task automatic test_wrap();
    logic [31:0] c = 32'hFFFF_FFF1;
    count = 32'hFFFF_FFF0;
    push(32'h5, 7);
    for (int k = 0; k < 22; k++) begin
      count = c;
      step();
      total++;
      if (bus.fire_valid !== (c == 32'd6)) begin
        bad++; $display("FAIL wrap_valid count=%0h got=%0b exp=%0b", c, bus.fire_valid, c == 32'd6);
      end
      c = c + 1;
    end
    total++; if (bus.fire_id !== 4'd7) begin bad++; $display("FAIL wrap_id got=%0h exp=7", bus.fire_id); end
    total++; if (bus.fire_time !== 32'd5) begin bad++; $display("FAIL wrap_time got=%0h exp=5", bus.fire_time); end
    total++; if (bus.fire_late !== 1'b0) begin bad++; $display("FAIL wrap_late got=%0b exp=0", bus.fire_late); end
    bus.fire_ready = 1'b1;
    step();
    bus.fire_ready = 1'b0;
  endtask

  task automatic test_late();
    count = 80;
    push(50, 9);
    count = 81;
    step();
`ifdef ALARM_LATE_DROP_EN
    total++; if (bus.fire_valid !== 1'b0) begin bad++; $display("FAIL late_drop_valid got=%0b exp=0", bus.fire_valid); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL late_drop_pending got=%0d exp=0", pending); end
    total++; if (late_drops !== 8'd1) begin bad++; $display("FAIL late_drops got=%0d exp=1", late_drops); end
`else
    total++; if (bus.fire_valid !== 1'b1) begin bad++; $display("FAIL late_valid got=%0b exp=1", bus.fire_valid); end
    total++; if (bus.fire_id !== 4'd9) begin bad++; $display("FAIL late_id got=%0h exp=9", bus.fire_id); end
    total++; if (bus.fire_late !== 1'b1) begin bad++; $display("FAIL late_flag got=%0b exp=1", bus.fire_late); end
    for (int k = 0; k < 5; k++) begin
      count = count + 1;
      step();
      total++;
      if (bus.fire_valid !== 1'b1 || bus.fire_time !== 32'd80) begin
        bad++; $display("FAIL late_hold got=v%0b/t%0d exp=v1/t80", bus.fire_valid, bus.fire_time);
      end
    end
    bus.fire_ready = 1'b1;
    step();
    bus.fire_ready = 1'b0;
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL late_pending got=%0d exp=0", pending); end
    total++; if (late_drops !== 8'd0) begin bad++; $display("FAIL late_drops got=%0d exp=0", late_drops); end
`endif
  endtask

  task automatic test_flush();
    int cyc = 0;
    count = 0;
    push(5, 1);
    push(6, 2);
    while (!bus.fire_valid && cyc < 20) begin
      count = count + 1;
      step();
      cyc++;
    end
    total++; if (bus.fire_valid !== 1'b1 || bus.fire_id !== 4'd1) begin
      bad++; $display("FAIL flush_pre_fire got=v%0b/id%0d exp=v1/id1", bus.fire_valid, bus.fire_id);
    end
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_time = 7; bus.in_id = 3;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", bus.in_ready); end
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.fire_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", bus.fire_valid); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL flush_pending got=%0d exp=0", pending); end
    count = 1000;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus.fire_valid !== 1'b0 || pending !== 3'd0) begin
        bad++; $display("FAIL flush_after got=v%0b/p%0d exp=v0/p0", bus.fire_valid, pending);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    count = 0;
    push(3, 5);
    while (!bus.fire_valid && cyc < 10) begin
      count = count + 1;
      step();
      cyc++;
    end
    total++; if (bus.fire_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_fire got=%0b exp=1", bus.fire_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (bus.fire_valid !== 1'b0 || bus.fire_id !== 4'd0 || bus.fire_time !== 32'd0
                 || bus.fire_late !== 1'b0 || pending !== 3'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_outputs got=v%0b/id%0d/t%0d/l%0b/p%0d/r%0b exp=v0/id0/t0/l0/p0/r1",
               bus.fire_valid, bus.fire_id, bus.fire_time, bus.fire_late, pending, bus.in_ready);
    end
    #2 reset = 1'b1;
    count = 500;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus.fire_valid !== 1'b0 || pending !== 3'd0) begin
        bad++; $display("FAIL rmid_after got=v%0b/p%0d exp=v0/p0", bus.fire_valid, pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_late();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
